// File: rtl/core_fetch_ctrl.sv
// core_fetch_ctrl: PC owner and req/ack ROM fetch sequencer feeding decode.
// Ports: clk/rst_n, jump_*_in, rom_* req/ack, inst_* valid/ready, misalign_out. Option: FETCH_MISALIGN_CHK_EN.
module core_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_en_in,
  input  logic [31:0] jump_addr_in,
  output logic        rom_req_out,
  output logic [31:0] rom_addr_out,
  input  logic        rom_ack_in,
  input  logic [31:0] rom_data_in,
  output logic        inst_valid_out,
  input  logic        inst_ready_in,
  output logic [31:0] inst_addr_out,
  output logic [31:0] inst_out,
  output logic        misalign_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        discard_q, discard_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic        misalign_q, misalign_d;

  logic        jump;
  logic [31:0] target;

`ifdef FETCH_MISALIGN_CHK_EN
  // Misaligned targets are dropped and flagged the following cycle.
  logic bad_tgt;
  assign bad_tgt    = |jump_addr_in[1:0];
  assign jump       = jump_en_in & ~bad_tgt;
  assign target     = jump_addr_in;
  assign misalign_d = jump_en_in & bad_tgt;
`else
  logic unused_lsb;
  assign unused_lsb = ^jump_addr_in[1:0];
  assign jump       = jump_en_in;
  assign target     = {jump_addr_in[31:2], 2'b00};
  assign misalign_d = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    discard_d   = discard_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (jump) begin
          pc_d       = target;
          req_addr_d = target;
        end else begin
          req_addr_d = pc_q;
        end
      end
      S_REQ: begin
        if (rom_ack_in) begin
          if (jump) begin
            discard_d  = 1'b0;
            pc_d       = target;
            req_addr_d = target;
          end else if (discard_q) begin
            discard_d  = 1'b0;
            req_addr_d = pc_q;
          end else begin
            valid_d     = 1'b1;
            inst_d      = rom_data_in;
            inst_addr_d = req_addr_q;
            pc_d        = req_addr_q + 32'd4;
            state_d     = S_OUT;
          end
        end else if (jump) begin
          // Address must stay put until the ROM acks; remember to drop it.
          discard_d = 1'b1;
          pc_d      = target;
        end
      end
      S_OUT: begin
        if (jump) begin
          valid_d    = 1'b0;
          inst_d     = NOP_INST;
          pc_d       = target;
          req_addr_d = target;
          state_d    = S_REQ;
        end else if (inst_ready_in) begin
          valid_d    = 1'b0;
          inst_d     = NOP_INST;
          req_addr_d = pc_q;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      discard_q   <= 1'b0;
      valid_q     <= 1'b0;
      inst_q      <= NOP_INST;
      inst_addr_q <= 32'd0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      discard_q   <= discard_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      inst_addr_q <= inst_addr_d;
      misalign_q  <= misalign_d;
    end
  end

  assign rom_req_out    = (state_q == S_REQ);
  assign rom_addr_out   = req_addr_q;
  assign inst_valid_out = valid_q;
  assign inst_out       = inst_q;
  assign inst_addr_out  = inst_addr_q;
  assign misalign_out   = misalign_q;

endmodule
